// File: rtl/issue_queue_steer_pkg.sv
// Package issue_pkg: decode constants and helpers shared by the issue stage.
// Instruction fields follow the classic MIPS32 layout:
//   [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [5:0] funct.
// Only the low 32 bits of an XLEN-wide instruction are decoded.
package issue_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [2:0] OP_IALU_HI = 3'b001;     // 001xxx: immediate ALU group
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [4:0] REG_RA     = 5'd31;

    typedef enum logic {
        ICLS_ALU    = 1'b0,
        ICLS_MEMCTL = 1'b1
    } iclass_e;

    typedef struct packed {
        iclass_e    cls;
        logic [4:0] dest;     // 0 = writes no register
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rt_vld;   // rt is a source operand
    } inst_info_t;

    // Memory/control instructions must go to way 0.
    function automatic logic is_way0_class(input logic [31:0] inst);
        case (inst[31:26])
            OP_RTYPE:                                  return inst[5:0] == FN_JR;
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] dest_reg(input logic [31:0] inst);
        case (inst[31:26])
            OP_RTYPE: return (inst[5:0] == FN_JR) ? 5'd0 : inst[15:11];
            OP_LW:    return inst[20:16];
            OP_JAL:   return REG_RA;
            default:  return (inst[31:29] == OP_IALU_HI) ? inst[20:16] : 5'd0;
        endcase
    endfunction

    function automatic logic reads_rt(input logic [31:0] inst);
        case (inst[31:26])
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/issue_queue_steer_if.sv
// Fetch / issue bus of the 2-way issue stage.
//   master: fetch + execute side (drives flush, fe_*, iss_ready)
//   slave : issue queue (drives fe_ready, w0_*, w1_*, occupancy)
interface issue_queue_steer_if #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
);
    localparam int OW = $clog2(DEPTH) + 1;

    logic            flush;
    logic [1:0]      fe_valid;
    logic [XLEN-1:0] fe_inst_0;
    logic [XLEN-1:0] fe_inst_1;
    logic [XLEN-1:0] fe_pc_0;
    logic [XLEN-1:0] fe_pc_1;
    logic            fe_ready;
    logic            iss_ready;
    logic            w0_valid;
    logic [XLEN-1:0] w0_inst;
    logic [XLEN-1:0] w0_pc;
    logic            w1_valid;
    logic [XLEN-1:0] w1_inst;
    logic [XLEN-1:0] w1_pc;
    logic            w0_oldest;
    logic            w0_busy;
    logic [OW-1:0]   occupancy;

    modport master (
        output flush, fe_valid, fe_inst_0, fe_inst_1, fe_pc_0, fe_pc_1, iss_ready,
        input  fe_ready, w0_valid, w0_inst, w0_pc, w1_valid, w1_inst, w1_pc,
               w0_oldest, w0_busy, occupancy
    );

    modport slave (
        input  flush, fe_valid, fe_inst_0, fe_inst_1, fe_pc_0, fe_pc_1, iss_ready,
        output fe_ready, w0_valid, w0_inst, w0_pc, w1_valid, w1_inst, w1_pc,
               w0_oldest, w0_busy, occupancy
    );

endinterface

// File: rtl/issue_queue_steer_classifier.sv
// inst_classifier: combinational decode of one queue slot.
//   inst_i : instruction word (low 32 bits decoded)
//   info_o : way class, destination register, rs/rt and whether rt is read
module inst_classifier
    import issue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] inst_i,
    output inst_info_t      info_o
);

    always_comb begin
        info_o        = '0;
        info_o.cls    = is_way0_class(inst_i[31:0]) ? ICLS_MEMCTL : ICLS_ALU;
        info_o.dest   = dest_reg(inst_i[31:0]);
        info_o.rs     = inst_i[25:21];
        info_o.rt     = inst_i[20:16];
        info_o.rt_vld = reads_rt(inst_i[31:0]);
    end

endmodule

// File: rtl/issue_queue_steer.sv
// issue_queue_steer: 2-way issue stage. Fetched instruction pairs are held in
// a DEPTH-entry circular queue; each cycle the two oldest entries are steered
// to way 0 (memory/control + ALU) and way 1 (ALU only).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : issue_queue_steer_if.slave (flush, fe_*, iss_ready in;
//                fe_ready, w0_*, w1_*, w0_oldest, w0_busy, occupancy out)
// Optional feature: define ISSUE_RAW_CHECK_EN to split a pair whose younger
// entry reads a register written by the older one.
module issue_queue_steer
    import issue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    issue_queue_steer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] DEPTH_W = OW'(DEPTH);

`ifdef ISSUE_RAW_CHECK_EN
    localparam bit RAW_EN = 1'b1;
`else
    localparam bit RAW_EN = 1'b0;
`endif

    logic [XLEN-1:0] inst_q [DEPTH];
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [OW-1:0]   occ_q, occ_d;

    // ---------------- head slots ----------------
    logic [PW-1:0]   slot_idx  [2];
    logic [XLEN-1:0] slot_inst [2];
    logic [XLEN-1:0] slot_pc   [2];
    inst_info_t      slot_info [2];
    logic [1:0]      slot_vld;

    assign slot_idx[0] = head_q;
    assign slot_idx[1] = head_q + PW'(1);
    assign slot_vld[0] = occ_q >= OW'(1);
    assign slot_vld[1] = occ_q >= OW'(2);

    for (genvar g = 0; g < 2; g++) begin : g_slot
        assign slot_inst[g] = inst_q[slot_idx[g]];
        assign slot_pc[g]   = pc_q[slot_idx[g]];
        inst_classifier #(.XLEN(XLEN)) u_cls (
            .inst_i (slot_inst[g]),
            .info_o (slot_info[g])
        );
    end

    // Younger slot consumes the older slot's result (x0 never counts).
    logic raw_hit;
    assign raw_hit = (slot_info[0].dest != 5'd0) &&
                     ((slot_info[1].rs == slot_info[0].dest) ||
                      (slot_info[1].rt_vld && slot_info[1].rt == slot_info[0].dest));

    // Fields the pair check never looks at.
    logic unused_info;
    assign unused_info = ^{slot_info[0].rs, slot_info[0].rt, slot_info[0].rt_vld,
                           slot_info[1].dest};

    // ---------------- steering ----------------
    logic            h_m, n_m, pair_ok;
    logic [1:0]      iss_cnt;
    logic            w0_valid, w1_valid, w0_oldest, w0_busy;
    logic [XLEN-1:0] w0_inst, w0_pc, w1_inst, w1_pc;

    assign h_m = slot_info[0].cls == ICLS_MEMCTL;
    assign n_m = slot_info[1].cls == ICLS_MEMCTL;
    // Only way 0 takes M, so two M's can never pair.
    assign pair_ok = slot_vld[1] && !(h_m && n_m) && !(RAW_EN && raw_hit);

    always_comb begin
        w0_valid  = 1'b0;
        w1_valid  = 1'b0;
        w0_inst   = '0;
        w0_pc     = '0;
        w1_inst   = '0;
        w1_pc     = '0;
        w0_oldest = 1'b0;
        w0_busy   = 1'b0;
        iss_cnt   = 2'd0;
        if (slot_vld[0]) begin
            if (pair_ok) begin
                iss_cnt  = 2'd2;
                w0_valid = 1'b1;
                w1_valid = 1'b1;
                if (h_m) begin
                    // head keeps way 0, younger ALU op rides on way 1
                    w0_inst   = slot_inst[0];
                    w0_pc     = slot_pc[0];
                    w1_inst   = slot_inst[1];
                    w1_pc     = slot_pc[1];
                    w0_oldest = 1'b1;
                end else begin
                    // ALU head moves to way 1, leaving way 0 for whatever follows
                    w1_inst   = slot_inst[0];
                    w1_pc     = slot_pc[0];
                    w0_inst   = slot_inst[1];
                    w0_pc     = slot_pc[1];
                end
            end else begin
                iss_cnt = 2'd1;
                w0_busy = slot_vld[1];
                if (h_m) begin
                    w0_valid  = 1'b1;
                    w0_inst   = slot_inst[0];
                    w0_pc     = slot_pc[0];
                    w0_oldest = 1'b1;
                end else begin
                    w1_valid = 1'b1;
                    w1_inst  = slot_inst[0];
                    w1_pc    = slot_pc[0];
                end
            end
        end
    end

    // ---------------- queue control ----------------
    logic       fe_ready, enq;
    logic [1:0] enq_cnt, deq_cnt;

    // Space is judged on current occupancy only; same-cycle issue does not help.
    assign fe_ready = rst_n && ((DEPTH_W - occ_q) >= OW'(2));
    assign enq      = bus.fe_valid[0] && fe_ready;
    assign enq_cnt  = enq ? (bus.fe_valid[1] ? 2'd2 : 2'd1) : 2'd0;
    assign deq_cnt  = bus.iss_ready ? iss_cnt : 2'd0;

    always_comb begin
        head_d = head_q + PW'(deq_cnt);
        tail_d = tail_q + PW'(enq_cnt);
        occ_d  = occ_q + OW'(enq_cnt) - OW'(deq_cnt);
        if (bus.flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Payload needs no reset: entries are only visible while counted in occ_q.
    always_ff @(posedge clk) begin
        if (enq && !bus.flush) begin
            inst_q[tail_q] <= bus.fe_inst_0;
            pc_q[tail_q]   <= bus.fe_pc_0;
            if (bus.fe_valid[1]) begin
                inst_q[tail_q + PW'(1)] <= bus.fe_inst_1;
                pc_q[tail_q + PW'(1)]   <= bus.fe_pc_1;
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.fe_ready  = fe_ready;
    assign bus.w0_valid  = w0_valid;
    assign bus.w0_inst   = w0_inst;
    assign bus.w0_pc     = w0_pc;
    assign bus.w1_valid  = w1_valid;
    assign bus.w1_inst   = w1_inst;
    assign bus.w1_pc     = w1_pc;
    assign bus.w0_oldest = w0_oldest;
    assign bus.w0_busy   = w0_busy;
    assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_issue_queue_steer.sv
// Self-checking bench for issue_queue_steer: directed scenarios plus a random
// run checked against a queue-based reference model.
module tb_issue_queue_steer;

    localparam int DEPTH = 8;
    localparam int XLEN  = 32;

`ifdef ISSUE_RAW_CHECK_EN
    localparam bit RAW_EN = 1'b1;
`else
    localparam bit RAW_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    issue_queue_steer_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

    issue_queue_steer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] pc_ctr = 32'h1000;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;
    ent_t mq[$];

    logic        e_w0v, e_w1v, e_old, e_busy, e_rdy;
    logic [31:0] e_w0i, e_w0p, e_w1i, e_w1p;
    logic [3:0]  e_cnt;
    int          e_issue;

    function automatic bit tb_mem(input logic [31:0] i);
        logic [5:0] op;
        op = i[31:26];
        if (op == 6'd0) return i[5:0] == 6'h08;
        return op == 6'h02 || op == 6'h03 || op == 6'h04 || op == 6'h05 ||
               op == 6'h23 || op == 6'h2b;
    endfunction

    function automatic logic [4:0] tb_dst(input logic [31:0] i);
        logic [5:0] op;
        op = i[31:26];
        if (op == 6'd0) return (i[5:0] == 6'h08) ? 5'd0 : i[15:11];
        if (op == 6'h23 || op[5:3] == 3'b001) return i[20:16];
        if (op == 6'h03) return 5'd31;
        return 5'd0;
    endfunction

    function automatic bit tb_dep(input logic [31:0] older, input logic [31:0] younger);
        logic [4:0] d;
        logic [5:0] op;
        bit         uses_rt;
        d  = tb_dst(older);
        op = younger[31:26];
        uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2b);
        if (d == 5'd0) return 1'b0;
        return (younger[25:21] == d) || (uses_rt && younger[20:16] == d);
    endfunction

    // What the ways should show for the current model contents.
    function automatic void model_expect();
        bit together;
        e_w0v = 0; e_w1v = 0; e_old = 0; e_busy = 0;
        e_w0i = 0; e_w0p = 0; e_w1i = 0; e_w1p = 0;
        e_cnt = 4'(mq.size());
        e_rdy = (DEPTH - mq.size()) >= 2;
        e_issue = 0;
        if (mq.size() == 0) return;
        together = 0;
        if (mq.size() >= 2)
            together = !(tb_mem(mq[0].inst) && tb_mem(mq[1].inst)) &&
                       !(RAW_EN && tb_dep(mq[0].inst, mq[1].inst));
        e_issue = together ? 2 : 1;
        e_busy  = !together && mq.size() >= 2;
        // An M head sits on way 0; an ALU head takes way 1 so way 0 is free for the next.
        if (tb_mem(mq[0].inst)) begin
            e_old = 1; e_w0v = 1; e_w0i = mq[0].inst; e_w0p = mq[0].pc;
            if (together) begin e_w1v = 1; e_w1i = mq[1].inst; e_w1p = mq[1].pc; end
        end else begin
            e_w1v = 1; e_w1i = mq[0].inst; e_w1p = mq[0].pc;
            if (together) begin e_w0v = 1; e_w0i = mq[1].inst; e_w0p = mq[1].pc; end
        end
    endfunction

    function automatic void model_step(input logic fl, input logic [1:0] fev,
                                       input logic [31:0] i0, input logic [31:0] p0,
                                       input logic [31:0] i1, input logic [31:0] p1,
                                       input logic ir);
        bit rdy;
        rdy = (DEPTH - mq.size()) >= 2;
        if (fl) begin mq.delete(); return; end
        if (ir) for (int k = 0; k < e_issue; k++) void'(mq.pop_front());
        if (fev[0] && rdy) begin
            mq.push_back('{inst: i0, pc: p0});
            if (fev[1]) mq.push_back('{inst: i1, pc: p1});
        end
    endfunction

    // One clock: present inputs, take the edge, advance the model, return at negedge.
    task automatic drive(input logic fl, input logic [1:0] fev,
                         input logic [31:0] i0, input logic [31:0] p0,
                         input logic [31:0] i1, input logic [31:0] p1,
                         input logic ir);
        bus.flush = fl; bus.fe_valid = fev; bus.iss_ready = ir;
        bus.fe_inst_0 = i0; bus.fe_pc_0 = p0; bus.fe_inst_1 = i1; bus.fe_pc_1 = p1;
        model_expect();
        @(posedge clk);
        model_step(fl, fev, i0, p0, i1, p1, ir);
        @(negedge clk);
        bus.flush = 0; bus.fe_valid = 2'b00; bus.iss_ready = 0;
    endtask

    function automatic logic [31:0] addi(input int k);
        return {6'h08, 5'd0, 5'(k), 16'(k)};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [4:0] rs, rt, rd;
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 12))
            0:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};        // ADD
            1:  return {6'h00, rs, rt, rd, 5'd0, 6'h22};        // SUB
            2:  return {6'h00, rs, 15'd0, 6'h08};               // JR
            3:  return {6'h08, rs, rt, 16'($urandom)};          // ADDI
            4:  return {6'h0d, rs, rt, 16'($urandom)};          // ORI
            5:  return {6'h23, rs, rt, 16'($urandom)};          // LW
            6:  return {6'h2b, rs, rt, 16'($urandom)};          // SW
            7:  return {6'h04, rs, rt, 16'($urandom)};          // BEQ
            8:  return {6'h05, rs, rt, 16'($urandom)};          // BNE
            9:  return {6'h02, 26'($urandom)};                  // J
            10: return {6'h03, 26'($urandom)};                  // JAL
            11: return {6'h0f, 5'd0, rt, 16'($urandom)};        // LUI
            default: return {6'h1c, rs, rt, 16'($urandom)};    // unlisted opcode
        endcase
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.flush = 0; bus.fe_valid = 0; bus.iss_ready = 0;
        bus.fe_inst_0 = 0; bus.fe_inst_1 = 0; bus.fe_pc_0 = 0; bus.fe_pc_1 = 0;
        rst_n = 0;
        mq.delete();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.w0_valid, bus.w1_valid, bus.w0_oldest, bus.w0_busy, bus.fe_ready} !== 5'b0 ||
            bus.occupancy !== 4'd0 || bus.w0_inst !== 0 || bus.w1_inst !== 0) begin
            errors++;
            $display("FAIL reset_outputs: got v0=%b v1=%b rdy=%b occ=%0d want all 0",
                     bus.w0_valid, bus.w1_valid, bus.fe_ready, bus.occupancy);
        end
        rst_n = 1;
        #1;
        checks++;
        if (bus.fe_ready !== 1'b1 || bus.occupancy !== 4'd0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b occ=%0d want rdy=1 occ=0", bus.fe_ready, bus.occupancy);
        end
        @(negedge clk);
    endtask

    task automatic test_pair_lw_add();
        drive(0, 2'b11, 32'h8C220004, 32'h100, 32'h00221820, 32'h104, 0);
        checks++;
        if (bus.occupancy !== 4'd2 || bus.w0_valid !== 1'b1 || bus.w0_inst !== 32'h8C220004 ||
            bus.w0_pc !== 32'h100 || bus.w0_oldest !== 1'b1) begin
            errors++;
            $display("FAIL lw_add_w0: got occ=%0d v=%b inst=%h pc=%h old=%b want occ=2 v=1 inst=8c220004 pc=100 old=1",
                     bus.occupancy, bus.w0_valid, bus.w0_inst, bus.w0_pc, bus.w0_oldest);
        end
        // LW writes $2 and ADD reads it, so the dependency check splits the pair.
        checks++;
        if (bus.w1_valid !== !RAW_EN || bus.w1_inst !== (RAW_EN ? 32'h0 : 32'h00221820) ||
            bus.w0_busy !== RAW_EN) begin
            errors++;
            $display("FAIL lw_add_w1: got v=%b inst=%h busy=%b want v=%b busy=%b",
                     bus.w1_valid, bus.w1_inst, bus.w0_busy, !RAW_EN, RAW_EN);
        end
        drive(0, 2'b00, 0, 0, 0, 0, 1);
        checks++;
        if (bus.occupancy !== (RAW_EN ? 4'd1 : 4'd0)) begin
            errors++;
            $display("FAIL lw_add_drain: got occ=%0d want %0d", bus.occupancy, RAW_EN ? 1 : 0);
        end
        if (RAW_EN) drive(0, 2'b00, 0, 0, 0, 0, 1);
    endtask

    task automatic test_split_lw_sw();
        drive(0, 2'b11, 32'h8C220004, 32'h200, 32'hAC230008, 32'h204, 0);
        checks++;
        if (bus.w0_valid !== 1'b1 || bus.w0_inst !== 32'h8C220004 || bus.w1_valid !== 1'b0 ||
            bus.w0_busy !== 1'b1 || bus.w0_oldest !== 1'b1) begin
            errors++;
            $display("FAIL split_c1: got w0v=%b w0=%h w1v=%b busy=%b old=%b want 1 8c220004 0 1 1",
                     bus.w0_valid, bus.w0_inst, bus.w1_valid, bus.w0_busy, bus.w0_oldest);
        end
        drive(0, 2'b00, 0, 0, 0, 0, 1);
        checks++;
        if (bus.w0_valid !== 1'b1 || bus.w0_inst !== 32'hAC230008 || bus.w0_pc !== 32'h204 ||
            bus.w0_busy !== 1'b0 || bus.w1_valid !== 1'b0 || bus.occupancy !== 4'd1) begin
            errors++;
            $display("FAIL split_c2: got w0v=%b w0=%h busy=%b w1v=%b occ=%0d want 1 ac230008 0 0 1",
                     bus.w0_valid, bus.w0_inst, bus.w0_busy, bus.w1_valid, bus.occupancy);
        end
        drive(0, 2'b00, 0, 0, 0, 0, 1);
        checks++;
        if (bus.occupancy !== 4'd0 || bus.w0_valid !== 1'b0) begin
            errors++;
            $display("FAIL split_drain: got occ=%0d w0v=%b want 0 0", bus.occupancy, bus.w0_valid);
        end
    endtask

    task automatic test_full_and_wrap();
        logic [31:0] exp_order[$];
        logic [31:0] got[$];
        int          nxt, enq_left;
        nxt = 1;
        for (int p = 0; p < 4; p++) begin
            exp_order.push_back(addi(nxt)); exp_order.push_back(addi(nxt + 1));
            drive(0, 2'b11, addi(nxt), 32'h300 + 4 * nxt, addi(nxt + 1), 32'h304 + 4 * nxt, 0);
            nxt += 2;
        end
        checks++;
        if (bus.occupancy !== 4'd8 || bus.fe_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state: got occ=%0d rdy=%b want 8 0", bus.occupancy, bus.fe_ready);
        end
        // A pair offered while full is dropped and the ways keep showing the head.
        drive(0, 2'b11, 32'hDEAD0000, 0, 32'hBEEF0000, 0, 0);
        checks++;
        if (bus.occupancy !== 4'd8 || bus.w1_inst !== addi(1) || bus.w0_inst !== addi(2) ||
            bus.w0_oldest !== 1'b0 || bus.w1_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_hold: got occ=%0d w1=%h w0=%h old=%b want 8 %h %h 0",
                     bus.occupancy, bus.w1_inst, bus.w0_inst, bus.w0_oldest, addi(1), addi(2));
        end
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1) begin
                // Second pass refills while draining so the pointers run past the top.
                for (int p = 0; p < 3; p++) begin
                    exp_order.push_back(addi(nxt)); exp_order.push_back(addi(nxt + 1));
                    drive(0, 2'b11, addi(nxt), 32'h300 + 4 * nxt, addi(nxt + 1), 32'h304 + 4 * nxt, 0);
                    nxt += 2;
                end
            end
            enq_left = (ph == 1) ? 3 : 0;
            for (int c = 0; c < 30 && (exp_order.size() > 0 || enq_left > 0); c++) begin
                got.delete();
                if (bus.w0_oldest) begin
                    if (bus.w0_valid) got.push_back(bus.w0_inst);
                    if (bus.w1_valid) got.push_back(bus.w1_inst);
                end else begin
                    if (bus.w1_valid) got.push_back(bus.w1_inst);
                    if (bus.w0_valid) got.push_back(bus.w0_inst);
                end
                foreach (got[k]) begin
                    checks++;
                    if (exp_order.size() == 0 || got[k] !== exp_order[0]) begin
                        errors++;
                        $display("FAIL drain_order: got %h want %h", got[k],
                                 exp_order.size() ? exp_order[0] : 32'h0);
                    end
                    if (exp_order.size() != 0) void'(exp_order.pop_front());
                end
                if (enq_left > 0 && (DEPTH - mq.size()) >= 2) begin
                    exp_order.push_back(addi(nxt)); exp_order.push_back(addi(nxt + 1));
                    drive(0, 2'b11, addi(nxt), 32'h300 + 4 * nxt, addi(nxt + 1), 32'h304 + 4 * nxt, 1);
                    nxt += 2;
                    enq_left--;
                end else begin
                    drive(0, 2'b00, 0, 0, 0, 0, 1);
                end
            end
            checks++;
            if (exp_order.size() != 0 || bus.occupancy !== 4'd0) begin
                errors++;
                $display("FAIL drain_done: got left=%0d occ=%0d want 0 0", exp_order.size(), bus.occupancy);
            end
        end
    endtask

    task automatic test_alu_head();
        drive(0, 2'b11, 32'h00221820, 32'h400, 32'h10220003, 32'h404, 0);
        checks++;
        if (bus.w1_valid !== 1'b1 || bus.w1_inst !== 32'h00221820 || bus.w0_valid !== 1'b1 ||
            bus.w0_inst !== 32'h10220003 || bus.w0_oldest !== 1'b0 || bus.w0_busy !== 1'b0) begin
            errors++;
            $display("FAIL add_beq: got w1=%b/%h w0=%b/%h old=%b busy=%b want 1/00221820 1/10220003 0 0",
                     bus.w1_valid, bus.w1_inst, bus.w0_valid, bus.w0_inst, bus.w0_oldest, bus.w0_busy);
        end
        drive(0, 2'b00, 0, 0, 0, 0, 1);
        // SUB $4,$3,$1 after ADD $3,...: paired unless the dependency check is built in.
        drive(0, 2'b11, 32'h00221820, 32'h500, 32'h00612022, 32'h504, 0);
        checks++;
        if (bus.w1_valid !== 1'b1 || bus.w1_inst !== 32'h00221820 || bus.w0_oldest !== 1'b0 ||
            bus.w0_valid !== !RAW_EN || bus.w0_busy !== RAW_EN ||
            bus.w0_inst !== (RAW_EN ? 32'h0 : 32'h00612022)) begin
            errors++;
            $display("FAIL add_sub: got w1=%b/%h w0=%b/%h busy=%b want w0v=%b busy=%b",
                     bus.w1_valid, bus.w1_inst, bus.w0_valid, bus.w0_inst, bus.w0_busy, !RAW_EN, RAW_EN);
        end
        for (int c = 0; c < 4 && mq.size() > 0; c++) drive(0, 2'b00, 0, 0, 0, 0, 1);
        checks++;
        if (bus.occupancy !== 4'd0) begin
            errors++;
            $display("FAIL add_sub_drain: got occ=%0d want 0", bus.occupancy);
        end
    endtask

    task automatic test_flush();
        drive(0, 2'b11, addi(20), 32'h600, addi(21), 32'h604, 0);
        drive(0, 2'b11, addi(22), 32'h608, addi(23), 32'h60c, 0);
        drive(0, 2'b01, addi(24), 32'h610, 0, 0, 0);
        checks++;
        if (bus.occupancy !== 4'd5) begin
            errors++;
            $display("FAIL flush_fill: got occ=%0d want 5", bus.occupancy);
        end
        drive(1, 2'b11, addi(25), 32'h614, addi(26), 32'h618, 1);
        checks++;
        if (bus.occupancy !== 4'd0 || bus.w0_valid !== 1'b0 || bus.w1_valid !== 1'b0 ||
            bus.fe_ready !== 1'b1 || bus.w0_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: got occ=%0d v0=%b v1=%b rdy=%b want 0 0 0 1",
                     bus.occupancy, bus.w0_valid, bus.w1_valid, bus.fe_ready);
        end
    endtask

    task automatic test_async_reset();
        for (int p = 0; p < 3; p++) drive(0, 2'b11, addi(p + 3), 32'h700 + 8 * p, addi(p + 8), 32'h704 + 8 * p, 0);
        drive(0, 2'b00, 0, 0, 0, 0, 1);
        #2 rst_n = 0;
        #1;
        mq.delete();
        checks++;
        if (bus.w0_valid !== 1'b0 || bus.w1_valid !== 1'b0 || bus.occupancy !== 4'd0 ||
            bus.w0_inst !== 0 || bus.w1_inst !== 0 || bus.fe_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: got v0=%b v1=%b occ=%0d rdy=%b want all 0",
                     bus.w0_valid, bus.w1_valid, bus.occupancy, bus.fe_ready);
        end
        @(negedge clk);
        rst_n = 1;
        drive(0, 2'b01, addi(30), 32'h800, 0, 0, 0);
        checks++;
        if (bus.w1_valid !== 1'b1 || bus.w1_inst !== addi(30) || bus.w1_pc !== 32'h800 ||
            bus.w0_valid !== 1'b0 || bus.w0_oldest !== 1'b0 || bus.w0_busy !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_single: got w1=%b/%h w0v=%b old=%b busy=%b want 1/%h 0 0 0",
                     bus.w1_valid, bus.w1_inst, bus.w0_valid, bus.w0_oldest, bus.w0_busy, addi(30));
        end
        drive(0, 2'b00, 0, 0, 0, 0, 1);
    endtask

    task automatic test_random(input int n);
        logic [1:0]  fev;
        logic [31:0] i0, i1;
        int          r;
        for (int c = 0; c < n; c++) begin
            model_expect();
            checks += 10;
            if (bus.w0_valid !== e_w0v) begin errors++; $display("FAIL rnd_w0_valid c=%0d: got %b want %b", c, bus.w0_valid, e_w0v); end
            if (bus.w1_valid !== e_w1v) begin errors++; $display("FAIL rnd_w1_valid c=%0d: got %b want %b", c, bus.w1_valid, e_w1v); end
            if (bus.w0_inst !== e_w0i) begin errors++; $display("FAIL rnd_w0_inst c=%0d: got %h want %h", c, bus.w0_inst, e_w0i); end
            if (bus.w0_pc !== e_w0p) begin errors++; $display("FAIL rnd_w0_pc c=%0d: got %h want %h", c, bus.w0_pc, e_w0p); end
            if (bus.w1_inst !== e_w1i) begin errors++; $display("FAIL rnd_w1_inst c=%0d: got %h want %h", c, bus.w1_inst, e_w1i); end
            if (bus.w1_pc !== e_w1p) begin errors++; $display("FAIL rnd_w1_pc c=%0d: got %h want %h", c, bus.w1_pc, e_w1p); end
            if (bus.w0_oldest !== e_old) begin errors++; $display("FAIL rnd_oldest c=%0d: got %b want %b", c, bus.w0_oldest, e_old); end
            if (bus.w0_busy !== e_busy) begin errors++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, bus.w0_busy, e_busy); end
            if (bus.occupancy !== e_cnt) begin errors++; $display("FAIL rnd_occ c=%0d: got %0d want %0d", c, bus.occupancy, e_cnt); end
            if (bus.fe_ready !== e_rdy) begin errors++; $display("FAIL rnd_fe_ready c=%0d: got %b want %b", c, bus.fe_ready, e_rdy); end
            r   = int'($urandom_range(0, 3));
            fev = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            i0  = rand_inst();
            i1  = rand_inst();
            drive(($urandom_range(0, 39) == 0), fev, i0, pc_ctr, i1, pc_ctr + 4,
                  ($urandom_range(0, 9) < (((c / 100) % 2) ? 3 : 8)));
            pc_ctr += 8;
        end
    endtask

    initial begin
        test_reset();
        test_pair_lw_add();
        test_split_lw_sw();
        test_full_and_wrap();
        test_alu_head();
        test_flush();
        test_async_reset();
        test_random(1500);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
